// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared constants for the unified instruction/data memory arbiter:
// response-state encoding, default bus widths and counter widths.
// Optional statistics counters are enabled with the ARB_STATS_EN macro.
package imem_dmem_arbiter_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 32;
  localparam int WAIT_W = 4;
  localparam int STAT_W = 16;

  // Owner of the read whose data appears on mem_rdata this cycle
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD_I = 2'd1;
  localparam logic [1:0] ST_RD_D = 2'd2;

  // Saturating increment for the statistics counters
  function automatic logic [STAT_W-1:0] stat_sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle for the arbiter: fetch port, load/store port and RAM port.
// slave = arbiter side, master = core + RAM side.
interface imem_dmem_arbiter_if
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_dmem_arb_prio.sv
// Combinational grant selector: data wins a conflict unless the fetch
// side has been starved long enough, in which case fetch is forced.
module imem_dmem_arb_prio (
  input  logic i_req,
  input  logic d_req,
  input  logic starve,
  output logic i_gnt,
  output logic d_gnt
);

  // One winner per cycle; at most one of the grants is high
  always_comb begin
    i_gnt = i_req & (~d_req | starve);
    d_gnt = d_req & ~(i_req & starve);
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and
// load/store. Grants are combinational; read data returns one cycle
// after the grant and is steered to the owner recorded at grant time.
// Optional: define ARB_STATS_EN for conflict / forced-grant counters.
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_WAIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_dmem_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]    stat_conflicts,
  output logic [STAT_W-1:0]    stat_forced
`endif
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic              w_i_req;
  logic              w_d_req;
  logic              w_starve;
  logic              w_i_gnt;
  logic              w_d_gnt;
  logic [1:0]        w_state_next;
  logic [1:0]        r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [DW-1:0]     r_i_rdata;
  logic [DW-1:0]     r_d_rdata;

  // Requests are masked during reset so every output reads zero
  assign w_i_req  = bus.i_req & ~rst;
  assign w_d_req  = bus.d_req & ~rst;
  assign w_starve = (r_wait_cnt == MAX_WAIT_C);

  imem_dmem_arb_prio u_prio (
    .i_req  (w_i_req),
    .d_req  (w_d_req),
    .starve (w_starve),
    .i_gnt  (w_i_gnt),
    .d_gnt  (w_d_gnt)
  );

  assign bus.i_gnt     = w_i_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.mem_en    = w_i_gnt | w_d_gnt;
  assign bus.mem_we    = w_d_gnt & bus.d_we;
  assign bus.mem_addr  = w_i_gnt ? bus.i_addr : (w_d_gnt ? bus.d_addr : '0);
  assign bus.mem_wdata = (w_d_gnt & bus.d_we) ? bus.d_wdata : '0;

  // Record which port owns the data that the RAM returns next cycle
  always_comb begin
    w_state_next = ST_IDLE;
    if (w_i_gnt)
      w_state_next = ST_RD_I;
    else if (w_d_gnt && !bus.d_we)
      w_state_next = ST_RD_D;
  end

  // Response owner register; reset drops any in-flight response
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  // Count consecutive denied fetch cycles, saturating at MAX_WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_wait_cnt <= '0;
    else if (w_i_req && !w_i_gnt) begin
      if (r_wait_cnt != MAX_WAIT_C)
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end else
      r_wait_cnt <= '0;
  end

  // Capture returned data so the non-owner output holds its last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (r_state == ST_RD_I)
        r_i_rdata <= bus.mem_rdata;
      if (r_state == ST_RD_D)
        r_d_rdata <= bus.mem_rdata;
    end
  end

  assign bus.i_rvalid = (r_state == ST_RD_I);
  assign bus.d_rvalid = (r_state == ST_RD_D);
  assign bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : r_i_rdata;
  assign bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : r_d_rdata;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] r_stat_conflicts;
  logic [STAT_W-1:0] r_stat_forced;

  // Conflict cycles and starvation-forced fetch grants, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_conflicts <= '0;
      r_stat_forced    <= '0;
    end else begin
      if (w_i_req && w_d_req)
        r_stat_conflicts <= stat_sat_inc(r_stat_conflicts);
      if (w_i_gnt && w_d_req)
        r_stat_forced <= stat_sat_inc(r_stat_forced);
    end
  end

  assign stat_conflicts = r_stat_conflicts;
  assign stat_forced    = r_stat_forced;
`endif

endmodule
